// File: rtl/alu16_pkg.sv
// Shared definitions for the alu16 pipeline: default width, ctrl bit positions and named ctrl encodings.
package alu16_pkg;

   localparam int WIDTH_DEF = 16;

   localparam int CTRL_ZX = 5;
   localparam int CTRL_NX = 4;
   localparam int CTRL_ZY = 3;
   localparam int CTRL_NY = 2;
   localparam int CTRL_F  = 1;
   localparam int CTRL_NO = 0;

   localparam logic [5:0] C_ZERO = 6'b101010;
   localparam logic [5:0] C_ONE  = 6'b111111;
   localparam logic [5:0] C_X    = 6'b001100;
   localparam logic [5:0] C_NOTX = 6'b001101;
   localparam logic [5:0] C_ADD  = 6'b000010;
   localparam logic [5:0] C_SUB  = 6'b010011;
   localparam logic [5:0] C_AND  = 6'b000000;

endpackage

// File: rtl/alu16_precond.sv
// Operand preconditioning: optionally zero the operand, then optionally invert it.
module alu16_precond
   import alu16_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic             z,
   input  logic             n,
   output logic [WIDTH-1:0] p
);

   logic [WIDTH-1:0] zeroed;

   assign zeroed = z ? '0 : a;
   assign p      = n ? ~zeroed : zeroed;

endmodule

// File: rtl/alu16_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 holds preconditioned operands, stage 2 the result and flags.
// Optional signed-add overflow flag with `define ALU_PIPE_OVF_EN.
module alu16_pipe
   import alu16_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [5:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
`ifdef ALU_PIPE_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH-1:0] xp_pre, yp_pre;
   logic [WIDTH-1:0] xp_q, xp_d, yp_q, yp_d;
   logic             f_q, f_d, no_q, no_d;
   logic             s1_v_q, s1_v_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zr_q, zr_d, ng_q, ng_d;
   logic             s2_v_q, s2_v_d;
   logic             s1_adv, s2_adv;
   logic [WIDTH-1:0] sum, g, r;

   alu16_precond #(.WIDTH(WIDTH)) u_pre_x (
      .a (x),
      .z (ctrl[CTRL_ZX]),
      .n (ctrl[CTRL_NX]),
      .p (xp_pre)
   );

   alu16_precond #(.WIDTH(WIDTH)) u_pre_y (
      .a (y),
      .z (ctrl[CTRL_ZY]),
      .n (ctrl[CTRL_NY]),
      .p (yp_pre)
   );

   assign s2_adv   = !s2_v_q || out_ready;
   assign s1_adv   = !s1_v_q || s2_adv;
   assign in_ready = s1_adv;

   assign sum = xp_q + yp_q;
   assign g   = f_q ? sum : (xp_q & yp_q);
   assign r   = no_q ? ~g : g;

   always_comb begin
      s1_v_d = s1_v_q;
      xp_d   = xp_q;
      yp_d   = yp_q;
      f_d    = f_q;
      no_d   = no_q;
      if (s1_adv) begin
         s1_v_d = in_valid;
         if (in_valid) begin
            xp_d = xp_pre;
            yp_d = yp_pre;
            f_d  = ctrl[CTRL_F];
            no_d = ctrl[CTRL_NO];
         end
      end
   end

   always_comb begin
      s2_v_d = s2_v_q;
      out_d  = out_q;
      zr_d   = zr_q;
      ng_d   = ng_q;
      if (s2_adv) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            out_d = r;
            zr_d  = (r == '0);
            ng_d  = r[WIDTH-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         xp_q   <= '0;
         yp_q   <= '0;
         f_q    <= 1'b0;
         no_q   <= 1'b0;
         s2_v_q <= 1'b0;
         out_q  <= '0;
         zr_q   <= 1'b0;
         ng_q   <= 1'b0;
      end else begin
         s1_v_q <= s1_v_d;
         xp_q   <= xp_d;
         yp_q   <= yp_d;
         f_q    <= f_d;
         no_q   <= no_d;
         s2_v_q <= s2_v_d;
         out_q  <= out_d;
         zr_q   <= zr_d;
         ng_q   <= ng_d;
      end
   end

`ifdef ALU_PIPE_OVF_EN
   logic ovf_q, ovf_d;

   // Overflow is judged on the raw sum, before any output inversion.
   always_comb begin
      ovf_d = ovf_q;
      if (s2_adv && s1_v_q) begin
         ovf_d = f_q && (xp_q[WIDTH-1] == yp_q[WIDTH-1]) && (sum[WIDTH-1] != xp_q[WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign out_valid = s2_v_q;
   assign out       = out_q;
   assign zr        = zr_q;
   assign ng        = ng_q;

endmodule
